// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction-fetch stage for the 16-bit single-cycle datapath. Owns the fetch
// PC, issues reads to a synchronous instruction memory (one cycle of latency),
// buffers the returned words in a small circular prefetch buffer and hands
// them to decode over a valid/ready handshake. A redirect from execute flushes
// the buffer and restarts fetch at a new PC.
//
// Parameters:
//   RESET_PC     PC loaded on reset (must be even)
//   DEPTH        prefetch buffer entries (power of 2, >= 2)
//
// Ports:
//   clock        system clock, rising-edge
//   reset_n      asynchronous active-low reset
//   imem_req     instruction read request this cycle
//   imem_addr    byte address of the request (always even)
//   imem_rdata   instruction word, valid the cycle after imem_req=1
//   if_valid     if_instr / if_pc hold a valid instruction
//   if_ready     decode accepts the instruction this cycle
//   if_instr     instruction at the buffer head
//   if_pc        byte address of if_instr
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch address (bit 0 ignored)
//
// Handshake: an instruction transfers to decode in every cycle where
// if_valid=1 and if_ready=1 (and redirect=0). While if_valid=1 and
// if_ready=0, if_instr and if_pc stay stable; if_valid never drops without a
// transfer except on redirect or reset.
// -----------------------------------------------------------------------------
module inst_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [15:0] if_instr,
   output logic [15:0] if_pc,
   input  logic        redirect,
   input  logic [15:0] redirect_pc
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [15:0]   pc;
   logic [15:0]   buf_instr [DEPTH];
   logic [15:0]   buf_pc    [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          inflight;
   logic [15:0]   inflight_pc;
   logic          drop;
   logic [15:0]   last_instr;
   logic [15:0]   last_pc;

   logic          pop;
   logic          push;
   logic [CW:0]   level;

   always_comb begin
      if_valid = (count != '0);
      // Redirect overrides both sides of the buffer in its cycle.
      pop  = if_valid & if_ready & ~redirect;
      push = inflight & ~drop & ~redirect;
      // Occupancy the buffer would have after this cycle's pop, counting the
      // response already on its way. Never underflows: pop implies count>=1.
      level = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
      imem_req  = reset_n & ~redirect & (level < (CW+1)'(DEPTH));
      imem_addr = pc;
      // With an empty buffer the outputs keep showing the last head entry.
      if (count != '0) begin
         if_instr = buf_instr[rd_ptr];
         if_pc    = buf_pc[rd_ptr];
      end else begin
         if_instr = last_instr;
         if_pc    = last_pc;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc          <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         drop        <= 1'b0;
         last_instr  <= '0;
         last_pc     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_instr[i] <= '0;
            buf_pc[i]    <= '0;
         end
      end else begin
         if (count != '0) begin
            last_instr <= buf_instr[rd_ptr];
            last_pc    <= buf_pc[rd_ptr];
         end

         if (redirect) begin
            // The request is suppressed in the redirect cycle and the
            // response arriving in it is discarded through push=0, so there
            // is nothing left in flight to drop afterwards.
            pc       <= redirect_pc & 16'hFFFE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            drop     <= 1'b0;
         end else begin
            if (imem_req) begin
               pc          <= pc + 16'd2;
               inflight_pc <= pc;
            end
            inflight <= imem_req;
            drop     <= 1'b0;

            if (push) begin
               buf_instr[wr_ptr] <= imem_rdata;
               buf_pc[wr_ptr]    <= inflight_pc;
               wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end

            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Directed, table-driven bench for inst_fetch. Two instances share the
// stimulus: dut_a uses the default RESET_PC, dut_b starts at 16'hFFFC for the
// address wrap case. Each instance has its own one-cycle-latency memory model
// whose word at byte address a is 16'h1000 + a/2.
//
// Cycle 0 is the cycle in which reset_n is released (just after a rising
// edge). Inputs are driven 1 time unit after the rising edge and outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

   logic        clock = 1'b0;
   logic        rst_a = 1'b0;
   logic        rst_b = 1'b0;
   logic        if_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;

   logic        req_a, req_b, valid_a, valid_b;
   logic [15:0] addr_a, addr_b, instr_a, instr_b, pc_a, pc_b;
   logic [15:0] rdata_a = 16'h0000;
   logic [15:0] rdata_b = 16'h0000;

   int checks = 0;
   int errors = 0;
   int sel    = 0;

   always #5 clock = ~clock;

   inst_fetch dut_a (
      .clock(clock), .reset_n(rst_a),
      .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
      .if_valid(valid_a), .if_ready(if_ready),
      .if_instr(instr_a), .if_pc(pc_a),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   inst_fetch #(.RESET_PC(16'hFFFC)) dut_b (
      .clock(clock), .reset_n(rst_b),
      .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
      .if_valid(valid_b), .if_ready(if_ready),
      .if_instr(instr_b), .if_pc(pc_b),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return 16'h1000 + {1'b0, a[15:1]};
   endfunction

   always @(posedge clock) begin
      if (req_a) rdata_a <= mem_word(addr_a);
      if (req_b) rdata_b <= mem_word(addr_b);
   end

   // Outputs of the instance under test.
   logic        o_req, o_valid;
   logic [15:0] o_addr, o_pc, o_instr;
   always_comb begin
      o_req   = (sel == 1) ? req_b   : req_a;
      o_valid = (sel == 1) ? valid_b : valid_a;
      o_addr  = (sel == 1) ? addr_b  : addr_a;
      o_pc    = (sel == 1) ? pc_b    : pc_a;
      o_instr = (sel == 1) ? instr_b : instr_a;
   end

   typedef struct {
      logic        ready;
      logic        redir;
      logic [15:0] rpc;
      logic        e_req;
      logic [15:0] e_addr;
      logic        e_valid;
      logic [15:0] e_pc;
      logic [15:0] e_instr;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int cyc,
                        input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic add(input logic ready, input logic redir, input logic [15:0] rpc,
                      input logic e_req, input logic [15:0] e_addr,
                      input logic e_valid, input logic [15:0] e_pc,
                      input logic [15:0] e_instr);
      vec_t v;
      v.ready = ready;  v.redir = redir;  v.rpc = rpc;
      v.e_req = e_req;  v.e_addr = e_addr;
      v.e_valid = e_valid;  v.e_pc = e_pc;  v.e_instr = e_instr;
      vecs.push_back(v);
   endtask

   task automatic set_reset(input logic val);
      if (sel == 1) rst_b = val;
      else          rst_a = val;
   endtask

   // Hold the selected instance in reset, check the reset outputs, then
   // release it in cycle 0 and apply/compare the table one cycle per entry.
   task automatic run(input string tag);
      if_ready = 1'b0;
      redirect = 1'b0;
      set_reset(1'b0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      check({tag, " rst valid"}, -1, {15'd0, o_valid}, 16'd0);
      check({tag, " rst req"},   -1, {15'd0, o_req},   16'd0);
      check({tag, " rst pc"},    -1, o_pc,    16'd0);
      check({tag, " rst instr"}, -1, o_instr, 16'd0);
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clock);
         #1;
         if_ready    = vecs[i].ready;
         redirect    = vecs[i].redir;
         redirect_pc = vecs[i].rpc;
         if (i == 0) set_reset(1'b1);
         @(negedge clock);
         check({tag, " req"},   i, {15'd0, o_req},   {15'd0, vecs[i].e_req});
         check({tag, " addr"},  i, o_addr,            vecs[i].e_addr);
         check({tag, " valid"}, i, {15'd0, o_valid}, {15'd0, vecs[i].e_valid});
         check({tag, " pc"},    i, o_pc,              vecs[i].e_pc);
         check({tag, " instr"}, i, o_instr,           vecs[i].e_instr);
      end
      @(posedge clock);
      #1;
      redirect = 1'b0;
      vecs.delete();
   endtask

   initial begin
      // Reset then stream, with a 6-cycle backpressure hold in cycles 3..8.
      sel = 0;
      add(1, 0, 16'h0, 1, 16'h0000, 0, 16'h0000, 16'h0000);
      add(1, 0, 16'h0, 1, 16'h0002, 0, 16'h0000, 16'h0000);
      add(1, 0, 16'h0, 1, 16'h0004, 1, 16'h0000, 16'h1000);
      for (int c = 3; c <= 8; c++)
         add(0, 0, 16'h0, 0, 16'h0006, 1, 16'h0002, 16'h1001);
      add(1, 0, 16'h0, 1, 16'h0006, 1, 16'h0002, 16'h1001);
      add(1, 0, 16'h0, 1, 16'h0008, 1, 16'h0004, 16'h1002);
      add(1, 0, 16'h0, 1, 16'h000A, 1, 16'h0006, 16'h1003);
      add(1, 0, 16'h0, 1, 16'h000C, 1, 16'h0008, 16'h1004);
      run("stream");

      // Redirect to 16'h0041 in cycle 5 with a request in flight.
      add(1, 0, 16'h0,    1, 16'h0000, 0, 16'h0000, 16'h0000);
      add(1, 0, 16'h0,    1, 16'h0002, 0, 16'h0000, 16'h0000);
      add(1, 0, 16'h0,    1, 16'h0004, 1, 16'h0000, 16'h1000);
      add(1, 0, 16'h0,    1, 16'h0006, 1, 16'h0002, 16'h1001);
      add(1, 0, 16'h0,    1, 16'h0008, 1, 16'h0004, 16'h1002);
      add(1, 1, 16'h0041, 0, 16'h000A, 1, 16'h0006, 16'h1003);
      add(1, 0, 16'h0,    1, 16'h0040, 0, 16'h0006, 16'h1003);
      add(1, 0, 16'h0,    1, 16'h0042, 0, 16'h0006, 16'h1003);
      add(1, 0, 16'h0,    1, 16'h0044, 1, 16'h0040, 16'h1020);
      add(1, 0, 16'h0,    1, 16'h0046, 1, 16'h0042, 16'h1021);
      run("redir");

      // Redirect to 16'h0100 while full and stalled.
      add(0, 0, 16'h0,    1, 16'h0000, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0,    1, 16'h0002, 0, 16'h0000, 16'h0000);
      add(0, 0, 16'h0,    0, 16'h0004, 1, 16'h0000, 16'h1000);
      add(0, 0, 16'h0,    0, 16'h0004, 1, 16'h0000, 16'h1000);
      add(0, 1, 16'h0100, 0, 16'h0004, 1, 16'h0000, 16'h1000);
      add(0, 0, 16'h0,    1, 16'h0100, 0, 16'h0000, 16'h1000);
      add(0, 0, 16'h0,    1, 16'h0102, 0, 16'h0000, 16'h1000);
      add(0, 0, 16'h0,    0, 16'h0104, 1, 16'h0100, 16'h1080);
      add(1, 0, 16'h0,    1, 16'h0104, 1, 16'h0100, 16'h1080);
      add(1, 0, 16'h0,    1, 16'h0106, 1, 16'h0102, 16'h1081);
      run("fullredir");

      // Reset mid-stream: stream a few cycles, then pull reset low mid-cycle.
      add(1, 0, 16'h0, 1, 16'h0000, 0, 16'h0000, 16'h0000);
      add(1, 0, 16'h0, 1, 16'h0002, 0, 16'h0000, 16'h0000);
      add(1, 0, 16'h0, 1, 16'h0004, 1, 16'h0000, 16'h1000);
      add(1, 0, 16'h0, 1, 16'h0006, 1, 16'h0002, 16'h1001);
      run("prereset");
      #2;
      rst_a = 1'b0;
      #1;
      check("midrst valid", 0, {15'd0, valid_a}, 16'd0);
      check("midrst req",   0, {15'd0, req_a},   16'd0);
      check("midrst pc",    0, pc_a,             16'd0);
      check("midrst addr",  0, addr_a,           16'd0);
      add(1, 0, 16'h0, 1, 16'h0000, 0, 16'h0000, 16'h0000);
      add(1, 0, 16'h0, 1, 16'h0002, 0, 16'h0000, 16'h0000);
      add(1, 0, 16'h0, 1, 16'h0004, 1, 16'h0000, 16'h1000);
      add(1, 0, 16'h0, 1, 16'h0006, 1, 16'h0002, 16'h1001);
      run("restart");

      // PC wrap from 16'hFFFC on the second instance.
      sel = 1;
      add(1, 0, 16'h0, 1, 16'hFFFC, 0, 16'h0000, 16'h0000);
      add(1, 0, 16'h0, 1, 16'hFFFE, 0, 16'h0000, 16'h0000);
      add(1, 0, 16'h0, 1, 16'h0000, 1, 16'hFFFC, 16'h8FFE);
      add(1, 0, 16'h0, 1, 16'h0002, 1, 16'hFFFE, 16'h8FFF);
      add(1, 0, 16'h0, 1, 16'h0004, 1, 16'h0000, 16'h1000);
      add(1, 0, 16'h0, 1, 16'h0006, 1, 16'h0002, 16'h1001);
      run("wrap");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
